// File: rtl/cpu_bus_if.sv
// CPU bus as seen by the primary slot selector: address/data, Z80 strobes and an access-start pulse.
// clk and reset travel with the bus so every stage shares one timing reference.
interface cpu_bus_if (
  input logic clk,
  input logic reset
);
  logic [15:0] addr;
  logic [7:0]  data;
  logic        mreq;
  logic        iorq;
  logic        rd;
  logic        wr;
  logic        req;
  logic        m1;

  modport device_mp (
    input clk, reset, addr, data, mreq, iorq, rd, wr, req, m1
  );

  modport host_mp (
    input  clk, reset,
    output addr, data, mreq, iorq, rd, wr, req, m1
  );
endinterface

// File: rtl/primary_slot.sv
// MSX primary slot register (PPI port A) with page decode and per-slot memory wait-state generator.
// Optional macro MSX_M1_WAIT_EN: adds one extra wait cycle to M1 (opcode fetch) memory accesses.
module primary_slot #(
  parameter logic [7:0] IO_ADDR = 8'hA8
) (
  cpu_bus_if.device_mp cpu_bus,
  input  logic [1:0]   slot_wait_conf [4],
  output logic [1:0]   active_slot,
  output logic [7:0]   data,
  output logic         output_rq,
  output logic         wait_n
);

  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    HOLD
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       psl;

  logic             io_sel;
  logic             io_wr;
  logic             io_rd;
  logic             start;
  logic [CNT_W-1:0] n;

  assign io_sel = (cpu_bus.addr[7:0] == IO_ADDR);
  assign io_wr  = cpu_bus.iorq && cpu_bus.wr && cpu_bus.req && io_sel;
  assign io_rd  = cpu_bus.iorq && cpu_bus.rd && io_sel;

  assign data      = io_rd ? psl : 8'hFF;
  assign output_rq = io_rd;

  // Each 16K page selects a 2-bit field of the register.
  assign active_slot = psl[{cpu_bus.addr[15:14], 1'b0} +: 2];

  // A req coinciding with reset is dropped, so it must not pull wait_n low either.
  assign start = (state == IDLE) && cpu_bus.mreq && cpu_bus.req && !cpu_bus.reset;

  always_comb begin
    n = CNT_W'(slot_wait_conf[active_slot]);
`ifdef MSX_M1_WAIT_EN
    if (cpu_bus.m1) n = n + CNT_W'(1);
`endif
  end

`ifndef MSX_M1_WAIT_EN
  logic unused_m1;
  assign unused_m1 = cpu_bus.m1;
`endif

  // The req cycle itself is the first wait cycle; COUNT supplies the remaining n-1.
  assign wait_n = !((start && (n != '0)) || (state == COUNT));

  always_ff @(posedge cpu_bus.clk) begin
    if (cpu_bus.reset) begin
      psl   <= 8'h00;
      state <= IDLE;
      cnt   <= '0;
    end else begin
      if (io_wr) psl <= cpu_bus.data;
      case (state)
        IDLE: begin
          if (start) begin
            if (n >= CNT_W'(2)) begin
              cnt   <= n - CNT_W'(2);
              state <= COUNT;
            end else begin
              state <= HOLD;
            end
          end
        end
        COUNT: begin
          if (cnt == '0) state <= HOLD;
          else           cnt   <= cnt - CNT_W'(1);
        end
        HOLD: begin
          if (!cpu_bus.mreq) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_primary_slot.sv
// Bench for primary_slot: table of single-cycle vectors plus hand-built wait-state sequences,
// expected outputs queued at drive time and compared when sampled.
module tb_primary_slot;

  typedef struct {
    logic        rst;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        mreq, iorq, rd, wr, req, m1;
    logic [1:0]  slot;
    logic [7:0]  rdata;
    logic        rq;
    logic        wn;
  } vec_t;

  logic       clk;
  logic       reset;
  logic [1:0] conf [4];
  logic [1:0] active_slot;
  logic [7:0] data;
  logic       output_rq;
  logic       wait_n;

  int n_vec;
  int n_err;

  vec_t sbq [$];
  vec_t tbl [$];

  cpu_bus_if bus (.clk(clk), .reset(reset));

  primary_slot #(.IO_ADDR(8'hA8)) dut (
    .cpu_bus        (bus.device_mp),
    .slot_wait_conf (conf),
    .active_slot    (active_slot),
    .data           (data),
    .output_rq      (output_rq),
    .wait_n         (wait_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic rst, input logic [15:0] addr, input logic [7:0] wdata,
                              input logic mreq, input logic iorq, input logic rd, input logic wr,
                              input logic req, input logic m1, input logic [1:0] slot,
                              input logic [7:0] rdata, input logic rq, input logic wn);
    vec_t v;
    v.rst = rst; v.addr = addr; v.wdata = wdata;
    v.mreq = mreq; v.iorq = iorq; v.rd = rd; v.wr = wr; v.req = req; v.m1 = m1;
    v.slot = slot; v.rdata = rdata; v.rq = rq; v.wn = wn;
    return v;
  endfunction

  function automatic int exp_n(input int k, input logic m1);
`ifdef MSX_M1_WAIT_EN
    return k + int'(m1);
`else
    return k + 0 * int'(m1);
`endif
  endfunction

  task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  // One bus cycle: drive after the rising edge, compare on the falling edge.
  task automatic step(input vec_t v, input int idx);
    vec_t e;
    @(posedge clk); #1;
    reset     = v.rst;
    bus.addr  = v.addr;
    bus.data  = v.wdata;
    bus.mreq  = v.mreq;
    bus.iorq  = v.iorq;
    bus.rd    = v.rd;
    bus.wr    = v.wr;
    bus.req   = v.req;
    bus.m1    = v.m1;
    sbq.push_back(v);
    @(negedge clk);
    e = sbq.pop_front();
    chk("active_slot", idx, 8'(active_slot), 8'(e.slot));
    chk("data",        idx, data,            e.rdata);
    chk("output_rq",   idx, 8'(output_rq),   8'(e.rq));
    chk("wait_n",      idx, 8'(wait_n),      8'(e.wn));
  endtask

  task automatic idle(input int idx);
    step(mk(0, 16'h0000, 8'h00, 0,0,0,0,0,0, 2'd0, 8'hFF, 0, 1), idx);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    bus.addr = '0; bus.data = '0;
    bus.mreq = 0; bus.iorq = 0; bus.rd = 0; bus.wr = 0; bus.req = 0; bus.m1 = 0;
    for (int i = 0; i < 4; i++) conf[i] = 2'd0;

    //          rst addr      wdata  mrq io rd wr rq m1 slot rdata  rq wn
    tbl.push_back(mk(1, 16'h0000, 8'h00, 0,0,0,0,0,0, 2'd0, 8'hFF, 0, 1));
    tbl.push_back(mk(1, 16'h0000, 8'h00, 0,0,0,0,0,0, 2'd0, 8'hFF, 0, 1));
    tbl.push_back(mk(0, 16'h0000, 8'h00, 0,0,0,0,0,0, 2'd0, 8'hFF, 0, 1));
    tbl.push_back(mk(0, 16'h4000, 8'h00, 1,0,1,0,1,0, 2'd0, 8'hFF, 0, 1));
    tbl.push_back(mk(0, 16'h4000, 8'h00, 1,0,1,0,0,0, 2'd0, 8'hFF, 0, 1));
    tbl.push_back(mk(0, 16'h0000, 8'h00, 0,0,0,0,0,0, 2'd0, 8'hFF, 0, 1));
    tbl.push_back(mk(0, 16'h00A8, 8'hE4, 0,1,0,1,1,0, 2'd0, 8'hFF, 0, 1));
    tbl.push_back(mk(0, 16'h12A8, 8'h00, 0,1,1,0,0,0, 2'd0, 8'hE4, 1, 1));
    tbl.push_back(mk(0, 16'h0000, 8'h00, 1,0,1,0,0,0, 2'd0, 8'hFF, 0, 1));
    tbl.push_back(mk(0, 16'h4000, 8'h00, 1,0,1,0,0,0, 2'd1, 8'hFF, 0, 1));
    tbl.push_back(mk(0, 16'h8000, 8'h00, 1,0,1,0,0,0, 2'd2, 8'hFF, 0, 1));
    tbl.push_back(mk(0, 16'hC000, 8'h00, 1,0,1,0,0,0, 2'd3, 8'hFF, 0, 1));
    tbl.push_back(mk(0, 16'h7FFF, 8'h00, 1,0,1,0,0,0, 2'd1, 8'hFF, 0, 1));
    tbl.push_back(mk(0, 16'hBFFF, 8'h00, 1,0,1,0,0,0, 2'd2, 8'hFF, 0, 1));
    tbl.push_back(mk(0, 16'hC0A8, 8'h00, 0,1,1,0,0,0, 2'd3, 8'hE4, 1, 1));
    tbl.push_back(mk(0, 16'h00A9, 8'h00, 0,1,1,0,0,0, 2'd0, 8'hFF, 0, 1));
    tbl.push_back(mk(0, 16'h00A9, 8'h55, 0,1,0,1,1,0, 2'd0, 8'hFF, 0, 1));
    tbl.push_back(mk(0, 16'h00A8, 8'h00, 0,1,1,0,1,0, 2'd0, 8'hE4, 1, 1));
    tbl.push_back(mk(0, 16'h4000, 8'h00, 1,0,1,0,0,0, 2'd1, 8'hFF, 0, 1));
    tbl.push_back(mk(0, 16'h00A8, 8'h20, 0,1,0,1,1,0, 2'd0, 8'hFF, 0, 1));
    tbl.push_back(mk(0, 16'h00A8, 8'h00, 0,1,1,0,0,0, 2'd0, 8'h20, 1, 1));
    tbl.push_back(mk(0, 16'h8000, 8'h00, 1,0,1,0,0,0, 2'd2, 8'hFF, 0, 1));
    tbl.push_back(mk(0, 16'h0000, 8'h00, 0,0,0,0,0,0, 2'd0, 8'hFF, 0, 1));

    foreach (tbl[i]) step(tbl[i], i);

    // Three-cycle wait on slot 2; extra req pulses in COUNT/HOLD must not extend it.
    conf[2] = 2'd3;
    step(mk(0, 16'h8000, 8'h00, 1,0,1,0,1,0, 2'd2, 8'hFF, 0, 0), 100);
    step(mk(0, 16'h8000, 8'h00, 1,0,1,0,1,0, 2'd2, 8'hFF, 0, 0), 101);
    step(mk(0, 16'h8000, 8'h00, 1,0,1,0,0,0, 2'd2, 8'hFF, 0, 0), 102);
    step(mk(0, 16'h8000, 8'h00, 1,0,1,0,1,0, 2'd2, 8'hFF, 0, 1), 103);
    step(mk(0, 16'h8000, 8'h00, 0,0,0,0,0,0, 2'd2, 8'hFF, 0, 1), 104);
    idle(105);

    // mreq drops mid-count: counting still runs out, then HOLD exits next edge.
    step(mk(0, 16'h8000, 8'h00, 1,0,1,0,1,0, 2'd2, 8'hFF, 0, 0), 110);
    step(mk(0, 16'h8000, 8'h00, 0,0,0,0,0,0, 2'd2, 8'hFF, 0, 0), 111);
    step(mk(0, 16'h8000, 8'h00, 0,0,0,0,0,0, 2'd2, 8'hFF, 0, 0), 112);
    step(mk(0, 16'h8000, 8'h00, 0,0,0,0,0,0, 2'd2, 8'hFF, 0, 1), 113);
    idle(114);

    // Sweep wait counts on slot 0 with and without M1.
    for (int k = 0; k < 4; k++) begin
      for (int m = 0; m < 2; m++) begin
        int nexp;
        nexp = exp_n(k, 1'(m));
        conf[0] = 2'(k);
        for (int c = 0; c < 6; c++)
          step(mk(0, 16'h0000, 8'h00, 1,0,1,0, 1'(c == 0), 1'(m), 2'd0, 8'hFF, 0, 1'(c >= nexp)),
               200 + 10 * (2 * k + m) + c);
        step(mk(0, 16'h0000, 8'h00, 0,0,0,0,0,0, 2'd0, 8'hFF, 0, 1), 200 + 10 * (2 * k + m) + 6);
        idle(200 + 10 * (2 * k + m) + 7);
      end
    end

    // Reset on the second cycle of a three-cycle wait, then a fresh 2-cycle access on slot 0.
    conf[0] = 2'd2;
    step(mk(0, 16'h8000, 8'h00, 1,0,1,0,1,0, 2'd2, 8'hFF, 0, 0), 300);
    step(mk(1, 16'h8000, 8'h00, 1,0,1,0,0,0, 2'd2, 8'hFF, 0, 0), 301);
    step(mk(0, 16'h8000, 8'h00, 1,0,1,0,0,0, 2'd0, 8'hFF, 0, 1), 302);
    step(mk(0, 16'h8000, 8'h00, 1,0,1,0,1,0, 2'd0, 8'hFF, 0, 0), 303);
    step(mk(0, 16'h8000, 8'h00, 1,0,1,0,0,0, 2'd0, 8'hFF, 0, 0), 304);
    step(mk(0, 16'h8000, 8'h00, 1,0,1,0,0,0, 2'd0, 8'hFF, 0, 1), 305);
    step(mk(0, 16'h0000, 8'h00, 0,0,0,0,0,0, 2'd0, 8'hFF, 0, 1), 306);
    step(mk(0, 16'h00A8, 8'h00, 0,1,1,0,0,0, 2'd0, 8'h00, 1, 1), 307);

    // A req arriving together with reset is dropped.
    step(mk(1, 16'h0000, 8'h00, 1,0,1,0,1,0, 2'd0, 8'hFF, 0, 1), 310);
    step(mk(0, 16'h0000, 8'h00, 1,0,1,0,0,0, 2'd0, 8'hFF, 0, 1), 311);
    idle(312);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
